// File: rtl/nwr_ireq_packetizer.sv
// Splits one user AXI4-Stream transfer (1..4096 bytes) into SRIO NWRITE packets of
// at most 256 bytes and emits them in HELLO format (header beat + payload beats) on ireq.
module nwr_ireq_packetizer #(
  parameter logic [15:0] SRC_ID  = 16'h0001,
  parameter logic [15:0] DEST_ID = 16'h00F0,
  parameter logic [1:0]  PRIO    = 2'b01
) (
  input  logic        log_clk,
  input  logic        log_rst,
  input  logic [33:0] user_addr_i,
  input  logic [11:0] user_tsize_i,
  input  logic [63:0] user_tdata_i,
  input  logic        user_tvalid_i,
  input  logic [7:0]  user_tkeep_i,
  input  logic        user_tlast_i,
  output logic        user_tready_o,
  output logic        nwr_ready_o,
  output logic        nwr_busy_o,
  output logic        nwr_done_o,
  output logic        nwr_err_o,
  output logic [63:0] ireq_tdata_o,
  output logic        ireq_tvalid_o,
  output logic [7:0]  ireq_tkeep_o,
  output logic        ireq_tlast_o,
  output logic [31:0] ireq_tuser_o,
  input  logic        ireq_tready_i
);

  typedef enum logic [1:0] {IDLE, HDR, DATA, DONE} state_t;

  state_t      state, state_nxt;

  logic        vld_p1;
  logic [63:0] data_p1;
  logic [7:0]  keep_p1;
  logic        last_p1;

  logic [33:0] cur_addr;
  logic [12:0] rem_bytes;
  logic [7:0]  tid;
  logic [8:0]  acc_left;
  logic        acc_done;
  logic [4:0]  beat_cnt;
  logic        err;

  logic [7:0]  len_m1;
  logic [12:0] pkt_bytes;
  logic        pkt_final;
  logic        accept;
  logic        drain;
  logic        beat_final;

  // Packet length minus one, saturated at a 256-byte packet.
  function automatic logic [7:0] sat_len_m1(input logic [12:0] rem);
    if (rem > 13'd256) return 8'hFF;
    else return 8'(rem - 13'd1);
  endfunction

  assign len_m1     = sat_len_m1(rem_bytes);
  assign pkt_bytes  = {5'd0, len_m1} + 13'd1;
  assign pkt_final  = (beat_cnt == len_m1[7:3]);

  assign user_tready_o = !acc_done && (!vld_p1 || (state == DATA && ireq_tready_i));
  assign accept        = user_tvalid_i && user_tready_o;
  assign drain         = (state == DATA) && vld_p1 && ireq_tready_i;
  assign beat_final    = (state == IDLE) ? (user_tsize_i[11:3] == 9'd0) : (acc_left == 9'd1);

  assign nwr_busy_o = (state != IDLE);
  assign nwr_err_o  = err;

  always_ff @(posedge log_clk) begin
    if (log_rst) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    nwr_ready_o   = 1'b0;
    nwr_done_o    = 1'b0;
    ireq_tvalid_o = 1'b0;
    ireq_tdata_o  = '0;
    ireq_tkeep_o  = '0;
    ireq_tlast_o  = 1'b0;
    ireq_tuser_o  = '0;
    case (state)
      IDLE: begin
        nwr_ready_o = 1'b1;
        if (accept) state_nxt = HDR;
      end
      HDR: begin
        ireq_tvalid_o = 1'b1;
        ireq_tkeep_o  = 8'hFF;
        ireq_tuser_o  = {SRC_ID, DEST_ID};
        ireq_tdata_o  = {tid, 4'h5, 4'h4, 1'b0, PRIO, 1'b0, len_m1, 2'b00, cur_addr};
        if (ireq_tready_i) state_nxt = DATA;
      end
      DATA: begin
        ireq_tvalid_o = vld_p1;
        ireq_tdata_o  = data_p1;
        ireq_tkeep_o  = keep_p1;
        ireq_tlast_o  = vld_p1 && pkt_final;
        ireq_tuser_o  = {SRC_ID, DEST_ID};
        if (drain && pkt_final) state_nxt = last_p1 ? DONE : HDR;
      end
      DONE: begin
        nwr_done_o = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Hold stage control: occupancy, beat accounting, packet sequencing
  always_ff @(posedge log_clk) begin
    if (log_rst) begin
      vld_p1    <= 1'b0;
      tid       <= 8'd0;
      acc_left  <= 9'd0;
      acc_done  <= 1'b0;
      beat_cnt  <= 5'd0;
      err       <= 1'b0;
      rem_bytes <= 13'd0;
    end else begin
      err <= accept && (user_tlast_i != beat_final);
      if (accept)     vld_p1 <= 1'b1;
      else if (drain) vld_p1 <= 1'b0;
      if (accept) begin
        if (state == IDLE) begin
          acc_left  <= user_tsize_i[11:3];
          acc_done  <= (user_tsize_i[11:3] == 9'd0);
          rem_bytes <= {1'b0, user_tsize_i} + 13'd1;
        end else begin
          acc_left <= acc_left - 9'd1;
          acc_done <= (acc_left == 9'd1);
        end
      end else if (state == DONE) begin
        acc_done <= 1'b0;
      end
      if (state == HDR && ireq_tready_i) tid <= tid + 8'd1;
      if (state == HDR) beat_cnt <= 5'd0;
      else if (drain)   beat_cnt <= beat_cnt + 5'd1;
      if (drain && pkt_final) rem_bytes <= rem_bytes - pkt_bytes;
    end
  end

  // Hold stage data and packet address
  always_ff @(posedge log_clk) begin
    if (accept) begin
      data_p1 <= user_tdata_i;
      keep_p1 <= beat_final ? user_tkeep_i : 8'hFF;
      last_p1 <= beat_final;
    end
    if (state == IDLE && accept)             cur_addr <= user_addr_i;
    else if (drain && pkt_final && !last_p1) cur_addr <= cur_addr + 34'd256;
  end

endmodule

// File: tb/tb_nwr_ireq_packetizer.sv
// Randomized scoreboard bench for nwr_ireq_packetizer: a packet-level reference model
// fills an expected-beat queue, and a negedge monitor pops and compares every ireq beat.
module tb_nwr_ireq_packetizer;

  localparam logic [15:0] SRC_M  = 16'h0001;
  localparam logic [15:0] DEST_M = 16'h00F0;
  localparam logic [1:0]  PRIO_M = 2'b01;

  logic        log_clk = 1'b0;
  logic        log_rst;
  logic [33:0] user_addr_i;
  logic [11:0] user_tsize_i;
  logic [63:0] user_tdata_i;
  logic        user_tvalid_i;
  logic [7:0]  user_tkeep_i;
  logic        user_tlast_i;
  logic        user_tready_o;
  logic        nwr_ready_o;
  logic        nwr_busy_o;
  logic        nwr_done_o;
  logic        nwr_err_o;
  logic [63:0] ireq_tdata_o;
  logic        ireq_tvalid_o;
  logic [7:0]  ireq_tkeep_o;
  logic        ireq_tlast_o;
  logic [31:0] ireq_tuser_o;
  logic        ireq_tready_i;

  always #5 log_clk = ~log_clk;

  nwr_ireq_packetizer dut (
    .log_clk       (log_clk),
    .log_rst       (log_rst),
    .user_addr_i   (user_addr_i),
    .user_tsize_i  (user_tsize_i),
    .user_tdata_i  (user_tdata_i),
    .user_tvalid_i (user_tvalid_i),
    .user_tkeep_i  (user_tkeep_i),
    .user_tlast_i  (user_tlast_i),
    .user_tready_o (user_tready_o),
    .nwr_ready_o   (nwr_ready_o),
    .nwr_busy_o    (nwr_busy_o),
    .nwr_done_o    (nwr_done_o),
    .nwr_err_o     (nwr_err_o),
    .ireq_tdata_o  (ireq_tdata_o),
    .ireq_tvalid_o (ireq_tvalid_o),
    .ireq_tkeep_o  (ireq_tkeep_o),
    .ireq_tlast_o  (ireq_tlast_o),
    .ireq_tuser_o  (ireq_tuser_o),
    .ireq_tready_i (ireq_tready_i)
  );

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } beat_t;

  beat_t       exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_seen = 0;
  int          err_seen = 0;
  int          ireq_beats = 0;
  int          exp_done = 0;
  int          exp_err = 0;
  logic [7:0]  tid_m = 8'd0;
  int          tready_mode = 0;
  bit          gap_en = 1'b0;

  logic [63:0] ud[512];
  logic [7:0]  uk[512];
  logic        ul[512];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ireq backpressure: 0 = always ready, 1 = toggle every cycle, 2 = random
  initial begin
    ireq_tready_i = 1'b1;
    forever begin
      @(posedge log_clk);
      #1;
      case (tready_mode)
        1:       ireq_tready_i = ~ireq_tready_i;
        2:       ireq_tready_i = 1'($urandom_range(0, 1));
        default: ireq_tready_i = 1'b1;
      endcase
    end
  end

  // Monitor: pops the scoreboard on every ireq handshake, checks stall stability
  initial begin
    beat_t       e;
    bit          stall_pend = 1'b0;
    logic [63:0] sd;
    logic [8:0]  sc;
    forever begin
      @(negedge log_clk);
      if (log_rst) begin
        stall_pend = 1'b0;
      end else begin
        if (nwr_done_o) done_seen++;
        if (nwr_err_o)  err_seen++;
        if (stall_pend) begin
          check("stall_data", ireq_tdata_o, sd);
          check("stall_ctl", {54'd0, ireq_tvalid_o, ireq_tkeep_o, ireq_tlast_o}, {54'd0, 1'b1, sc});
        end
        if (ireq_tvalid_o && ireq_tready_i) begin
          ireq_beats++;
          stall_pend = 1'b0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", ireq_tdata_o);
          end else begin
            e = exp_q.pop_front();
            check("beat_data", ireq_tdata_o, e.d);
            check("beat_ctl", {23'd0, ireq_tkeep_o, ireq_tlast_o, ireq_tuser_o},
                  {23'd0, e.k, e.l, SRC_M, DEST_M});
          end
        end else if (ireq_tvalid_o) begin
          stall_pend = 1'b1;
          sd = ireq_tdata_o;
          sc = {ireq_tkeep_o, ireq_tlast_o};
        end else begin
          stall_pend = 1'b0;
        end
      end
    end
  end

  task automatic do_reset();
    log_rst       = 1'b1;
    user_tvalid_i = 1'b0;
    repeat (2) @(posedge log_clk);
    #1;
    log_rst = 1'b0;
    tid_m   = 8'd0;
    exp_q.delete();
  endtask

  // Builds the expected packet stream, then drives the user beats.
  // bad_last >= 0 raises tlast early on that beat; rst_at >= 0 resets after that many beats.
  task automatic run_transfer(input logic [33:0] addr, input logic [11:0] tsize,
                              input int bad_last, input int rst_at);
    int    nb;
    int    bytes;
    int    pb;
    int    pbeats;
    int    idx;
    int    t;
    beat_t b;
    nb    = int'(tsize[11:3]) + 1;
    bytes = int'(tsize) + 1;
    for (int i = 0; i < nb; i++) begin
      ud[i] = {$urandom, $urandom};
      uk[i] = (i == nb - 1) ? (8'hFF << (7 - tsize[2:0])) : 8'hFF;
      ul[i] = (i == nb - 1) || (i == bad_last);
    end
    for (int off = 0; off < bytes; off += 256) begin
      pb     = (bytes - off > 256) ? 256 : bytes - off;
      pbeats = (pb + 7) / 8;
      b.d = {tid_m, 4'h5, 4'h4, 1'b0, PRIO_M, 1'b0, 8'(pb - 1), 2'b00, addr + 34'(off)};
      b.k = 8'hFF;
      b.l = 1'b0;
      exp_q.push_back(b);
      for (int j = 0; j < pbeats; j++) begin
        idx = off / 8 + j;
        b.d = ud[idx];
        b.k = (idx == nb - 1) ? uk[idx] : 8'hFF;
        b.l = (j == pbeats - 1);
        exp_q.push_back(b);
      end
      tid_m++;
    end
    if (bad_last >= 0 && bad_last != nb - 1) exp_err++;

    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        user_tvalid_i = 1'b0;
        log_rst       = 1'b1;
        @(posedge log_clk);
        #1;
        log_rst = 1'b0;
        exp_q.delete();
        tid_m = 8'd0;
        @(negedge log_clk);
        check("rst_ready", 64'(nwr_ready_o), 64'd1);
        check("rst_tvalid", 64'(ireq_tvalid_o), 64'd0);
        check("rst_busy", 64'(nwr_busy_o), 64'd0);
        @(posedge log_clk);
        #1;
        return;
      end
      if (gap_en && $urandom_range(0, 3) == 0) begin
        user_tvalid_i = 1'b0;
        @(posedge log_clk);
        #1;
      end
      user_addr_i   = addr;
      user_tsize_i  = tsize;
      user_tdata_i  = ud[i];
      user_tkeep_i  = uk[i];
      user_tlast_i  = ul[i];
      user_tvalid_i = 1'b1;
      t = 0;
      @(negedge log_clk);
      while (!user_tready_o && t < 2000) begin
        @(negedge log_clk);
        t++;
      end
      if (t >= 2000) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout actual=beat%0d required=accepted", i);
        user_tvalid_i = 1'b0;
        return;
      end
      @(posedge log_clk);
      #1;
    end
    user_tvalid_i = 1'b0;
    user_tlast_i  = 1'b0;
    exp_done++;
    t = 0;
    while (done_seen < exp_done && t < 20000) begin
      @(negedge log_clk);
      t++;
    end
    repeat (3) @(negedge log_clk);
    check("done_count", 64'(done_seen), 64'(exp_done));
    check("err_count", 64'(err_seen), 64'(exp_err));
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    check("idle_ready", 64'({nwr_ready_o, nwr_busy_o, user_tready_o}), 64'b101);
    @(posedge log_clk);
    #1;
  endtask

  initial begin
    int b0;
    log_rst       = 1'b1;
    user_addr_i   = '0;
    user_tsize_i  = '0;
    user_tdata_i  = '0;
    user_tvalid_i = 1'b0;
    user_tkeep_i  = '0;
    user_tlast_i  = 1'b0;
    repeat (3) @(posedge log_clk);
    #1;
    log_rst = 1'b0;
    @(negedge log_clk);
    check("reset_status", 64'({user_tready_o, nwr_ready_o, nwr_busy_o, nwr_done_o, nwr_err_o}),
          64'b11000);
    check("reset_ireq", 64'({ireq_tvalid_o, ireq_tlast_o, ireq_tkeep_o}), 64'd0);
    check("reset_tdata", ireq_tdata_o, 64'd0);
    @(posedge log_clk);
    #1;

    tready_mode = 0;
    run_transfer(34'h0_0000_1000, 12'd127, -1, -1);
    do_reset();
    run_transfer(34'h0_0000_2000, 12'd256, -1, -1);
    do_reset();
    b0 = ireq_beats;
    run_transfer(34'h0_0000_0000, 12'd4095, -1, -1);
    check("beats_4095", 64'(ireq_beats - b0), 64'd528);
    do_reset();
    tready_mode = 1;
    run_transfer(34'h0_0000_3000, 12'd259, -1, -1);
    tready_mode = 0;
    run_transfer(34'h0_0000_4000, 12'd127, 2, -1);
    run_transfer(34'h0_0000_5000, 12'd511, -1, 10);
    run_transfer(34'h0_0000_6000, 12'd63, -1, -1);

    tready_mode = 2;
    gap_en      = 1'b1;
    for (int n = 0; n < 8; n++) begin
      run_transfer({2'($urandom_range(0, 3)), $urandom}, 12'($urandom_range(0, 4095)),
                   (n == 3) ? 0 : -1, -1);
    end
    run_transfer(34'h3_FFFF_FF00, 12'd600, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
